gsm_cmd_sender: RTL and testbench
=================================

Name: gsm_cmd_sender

Overview:
Parametrised successor to the three-trigger GSM AT-command transmitter. Accepts N_CH independent trigger inputs and latches each as a pending request. Arbitrates pending requests by fixed priority and streams the selected channel's command string out of an 8N1 UART transmitter, with an integrated baud generator. Sits between application logic (alarm/event sources) and the GSM module's RX pin.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
BAUD, 9600, line rate; DIV = CLK_HZ/BAUD clocks per bit (integer divide, must be >= 2).
N_CH, 3, number of trigger channels (1..8).
MAX_LEN, 32, maximum bytes per command string; index width IW = clog2(MAX_LEN).
GAP_BITS, 10, idle bit-times inserted after each string before the next arbitration.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
trig  in  N_CH  per-channel request; a 0->1 transition (sampled on clk) raises a request.
clr_pending  in  1  one-cycle strobe; clears all pending requests not yet in transmission.
tx  out  1  UART serial output, idle high.
busy  out  1  high from LOAD through the end of GAP.
active_ch  out  clog2(N_CH) (min 1)  channel being sent; valid while busy.
msg_done  out  1  one-cycle pulse on the clock where the STOP bit of the final byte completes.
pending  out  N_CH  current pending mask.

Behaviour:
- Reset: tx=1, busy=0, active_ch=0, msg_done=0, pending=0, edge-detect register loaded with 0, FSM=IDLE, baud and bit counters=0. Reset mid-frame truncates the frame: tx is 1 on the cycle after rst is sampled high.
- Edge detect: trig_q registered each cycle; rise = trig & ~trig_q. A rise sets pending[i] on the next cycle.
- A rise on the channel currently being sent re-arms that channel; it is sent again after the current one.
- clr_pending and a rise on the same cycle: rise wins for that bit.
- FSM states: IDLE, LOAD, START, DATA, STOP, GAP.
- IDLE: if pending!=0, select lowest index i with pending[i]=1; clear pending[i]; active_ch=i; go to LOAD.
- LOAD: one cycle; fetch ROM byte at (active_ch, idx), where idx=0 for the first byte.
- START: tx=0 for DIV clocks.
- DATA: 8 bits LSB first, DIV clocks each.
- STOP: tx=1 for DIV clocks. At the end of STOP:
  - if the ROM last flag was set for this byte, or idx==MAX_LEN-1: pulse msg_done and go to GAP;
  - otherwise idx++ and go to LOAD.
- Each byte costs 1 LOAD clock + 10*DIV clocks.
- GAP: tx=1 for GAP_BITS*DIV clocks, then IDLE. Arbitration happens only in IDLE, so priority never preempts a string in progress.
- Baud counter: counts 0..DIV-1 and restarts at every state entry; no free-running phase drift.
- busy=1 in all states except IDLE. active_ch holds its value after return to IDLE.
- A channel with an empty ROM entry (byte 0 has last=1, data=0x00) still sends one 0x00 byte. The ROM must never be empty.

Decomposition:
- Shared package gsm_pkg holds:
  - state enum;
  - constants AT_CR=8'h0D, AT_LF=8'h0A, CTRL_Z=8'h1A;
  - function clog2.
- Sub-module gsm_cmd_rom: combinational (ch, idx) -> {last, byte[7:0]}. Contents are a case table per channel, e.g.:
  - ch0 "AT\r";
  - ch1 "AT+CMGF=1\r";
  - ch2 "AT+CMGS=\"...\"\r" ... CTRL_Z.
- Baud/bit counting stays in the main module.

Test Plan:
- CLK_HZ=1000, BAUD=100 (DIV=10), ch0="AT\r". Pulse trig[0] -> start bit falls 2 clocks after trig rise; bytes 0x41,0x54,0x0D sent LSB first, each bit 10 clocks. msg_done pulses 3*101 clocks after LOAD entry. busy drops 100 clocks later.
- Simultaneous rise on trig[2] and trig[1] -> ch1 string sent first, then GAP, then ch2. pending reads 3'b100 during the ch1 string.
- trig[0] held high for 500 clocks -> exactly one transmission. Release and re-raise during GAP -> second transmission starts right after GAP.
- Assert rst during bit 4 of byte 1 -> tx=1 next cycle, busy=0, pending=0. No msg_done pulse.
- Rise trig[1], then clr_pending while ch0 is sending -> ch1 never sent. clr_pending coincident with a trig[2] rise -> pending=3'b100.
- MAX_LEN=4 with a ch2 string lacking a last flag -> exactly 4 bytes sent, then msg_done pulses.

Source files
------------

// File: rtl/gsm_pkg.sv
// Shared types and constants for the GSM AT-command sender.
package gsm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StStop,
        StGap
    } state_e;

    localparam logic [7:0] AT_CR  = 8'h0D;
    localparam logic [7:0] AT_LF  = 8'h0A;
    localparam logic [7:0] CTRL_Z = 8'h1A;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/gsm_cmd_rom.sv
// Command string table: (channel, byte index) -> {last flag, byte}.
module gsm_cmd_rom import gsm_pkg::*; #(
    parameter int unsigned N_CH    = 3,
    parameter int unsigned MAX_LEN = 32,
    localparam int unsigned CHW    = (N_CH > 1) ? clog2(N_CH) : 1,
    localparam int unsigned IW     = (MAX_LEN > 1) ? clog2(MAX_LEN) : 1
) (
    input  logic [CHW-1:0] ch_i,
    input  logic [IW-1:0]  idx_i,
    output logic           last_o,
    output logic [7:0]     data_o
);

    localparam int unsigned Len0 = 3;
    localparam int unsigned Len1 = 10;
    localparam int unsigned Len2 = 26;

    // Strings are stored first-character-in-MSB.
    localparam logic [8*Len0-1:0] Str0 = {"AT", AT_CR};
    localparam logic [8*Len1-1:0] Str1 = {"AT+CMGF=1", AT_CR};
    localparam logic [8*Len2-1:0] Str2 = {"AT+CMGS=\"+15551234\"", AT_CR, "ALARM", CTRL_Z};

    logic [31:0] ch;
    logic [31:0] idx;

    always_comb begin
        ch     = 32'(ch_i);
        idx    = 32'(idx_i);
        last_o = 1'b1;
        data_o = 8'h00;
        case (ch)
            32'd0: begin
                if (idx < Len0) begin
                    data_o = Str0[8*(Len0-1-idx) +: 8];
                    last_o = (idx == Len0 - 1);
                end
            end
            32'd1: begin
                if (idx < Len1) begin
                    data_o = Str1[8*(Len1-1-idx) +: 8];
                    last_o = (idx == Len1 - 1);
                end
            end
            32'd2: begin
                if (idx < Len2) begin
                    data_o = Str2[8*(Len2-1-idx) +: 8];
                    last_o = (idx == Len2 - 1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gsm_cmd_sender.sv
// Latches per-channel triggers, arbitrates by fixed priority and streams the
// selected command string out of an 8N1 UART.
module gsm_cmd_sender import gsm_pkg::*; #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned N_CH     = 3,
    parameter int unsigned MAX_LEN  = 32,
    parameter int unsigned GAP_BITS = 10,
    localparam int unsigned CHW     = (N_CH > 1) ? clog2(N_CH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] trig_i,
    input  logic            clr_pending_i,
    output logic            tx_o,
    output logic            busy_o,
    output logic [CHW-1:0]  active_ch_o,
    output logic            msg_done_o,
    output logic [N_CH-1:0] pending_o
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned BW  = clog2(DIV);
    localparam int unsigned IW  = (MAX_LEN > 1) ? clog2(MAX_LEN) : 1;
    localparam int unsigned CW  = clog2((GAP_BITS > 8) ? GAP_BITS : 8);

    localparam logic [BW-1:0] BaudLast = BW'(DIV - 1);
    localparam logic [CW-1:0] GapLast  = CW'(GAP_BITS - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(MAX_LEN - 1);

    state_e          state_q, state_d;
    logic [N_CH-1:0] trig_q;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            last_q, last_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [CW-1:0]   bit_q, bit_d;
    logic            msg_done_q;

    logic [N_CH-1:0] rise;
    logic [CHW-1:0]  sel;
    logic            grant;
    logic            baud_tick;
    logic            str_end;
    logic            msg_end;
    logic            rom_last;
    logic [7:0]      rom_data;

    gsm_cmd_rom #(
        .N_CH    (N_CH),
        .MAX_LEN (MAX_LEN)
    ) u_rom (
        .ch_i   (ch_q),
        .idx_i  (idx_q),
        .last_o (rom_last),
        .data_o (rom_data)
    );

    assign rise      = trig_i & ~trig_q;
    assign grant     = (state_q == StIdle) && (|pending_q);
    assign baud_tick = (baud_q == BaudLast);
    assign str_end   = last_q || (idx_q == IdxLast);
    assign msg_end   = (state_q == StStop) && baud_tick && str_end;

    always_comb begin
        sel = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (pending_q[i]) sel = CHW'(i);
        end
    end

    // A fresh rise overrides both the clear strobe and the grant of its own bit.
    always_comb begin
        pending_d = pending_q;
        if (clr_pending_i) pending_d = '0;
        if (grant) pending_d[sel] = 1'b0;
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            trig_q     <= '0;
            pending_q  <= '0;
            ch_q       <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            last_q     <= 1'b0;
            baud_q     <= '0;
            bit_q      <= '0;
            msg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_i;
            pending_q  <= pending_d;
            ch_q       <= ch_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            msg_done_q <= msg_end;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
                if (grant) begin
                    state_d = StLoad;
                    ch_d    = sel;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                shreg_d = rom_data;
                last_d  = rom_last;
                baud_d  = '0;
                bit_d   = '0;
                state_d = StStart;
            end
            StStart: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == CW'(7)) begin
                        bit_d   = '0;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (str_end) begin
                        state_d = StGap;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StLoad;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StGap: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (bit_q == GapLast) begin
                        bit_d   = '0;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_o        = 1'b1;
        busy_o      = (state_q != StIdle);
        active_ch_o = ch_q;
        msg_done_o  = msg_done_q;
        pending_o   = pending_q;
        case (state_q)
            StStart: tx_o = 1'b0;
            StData:  tx_o = shreg_q[0];
            default: tx_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_gsm_cmd_sender.sv
// Directed bench for gsm_cmd_sender with a UART-decoding scoreboard.
module tb_gsm_cmd_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] trig_a, trig_b;
    logic       clr_a, clr_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;
    logic [1:0] ach_a, ach_b;
    logic [2:0] pend_a, pend_b;

    int total = 0;
    int bad   = 0;
    int epoch = 0;
    int n;
    int nd, nb;

    logic [10:0] qa[$];
    logic [10:0] qb[$];

    gsm_cmd_sender #(
        .CLK_HZ(1000), .BAUD(100), .N_CH(3), .MAX_LEN(32), .GAP_BITS(10)
    ) u_dut_a (
        .clk_i         (clk),
        .rst_i         (rst),
        .trig_i        (trig_a),
        .clr_pending_i (clr_a),
        .tx_o          (tx_a),
        .busy_o        (busy_a),
        .active_ch_o   (ach_a),
        .msg_done_o    (done_a),
        .pending_o     (pend_a)
    );

    gsm_cmd_sender #(
        .CLK_HZ(1000), .BAUD(100), .N_CH(3), .MAX_LEN(4), .GAP_BITS(10)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .trig_i        (trig_b),
        .clr_pending_i (clr_b),
        .tx_o          (tx_b),
        .busy_o        (busy_b),
        .active_ch_o   (ach_b),
        .msg_done_o    (done_b),
        .pending_o     (pend_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic [1:0] get_ach(input int w);
        return (w == 0) ? ach_a : ach_b;
    endfunction

    function automatic logic cond(input int w, input int what);
        logic d, b;
        d = (w == 0) ? done_a : done_b;
        b = (w == 0) ? busy_a : busy_b;
        case (what)
            0:       return d === 1'b1;
            1:       return b === 1'b0;
            default: return b === 1'b1;
        endcase
    endfunction

    // Counts negedges until the condition holds; a missed bound is a failure.
    task automatic wait_for(input int w, input int what, input int limit, input string tag,
                            output int cnt);
        logic hit;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            hit = cond(w, what);
        end while (!hit && cnt < limit);
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic push_b(input int w, input logic [1:0] ch, input logic [7:0] b);
        if (w == 0) qa.push_back({ch, 1'b1, b});
        else        qb.push_back({ch, 1'b1, b});
    endtask

    task automatic push_str(input int w, input logic [1:0] ch, input string s);
        for (int i = 0; i < s.len(); i++) push_b(w, ch, s[i]);
    endtask

    task automatic push_ch0();
        push_str(0, 2'd0, "AT");
        push_b(0, 2'd0, 8'h0D);
    endtask

    task automatic push_ch1();
        push_str(0, 2'd1, "AT+CMGF=1");
        push_b(0, 2'd1, 8'h0D);
    endtask

    task automatic push_ch2();
        push_str(0, 2'd2, "AT+CMGS=\"+15551234\"");
        push_b(0, 2'd2, 8'h0D);
        push_str(0, 2'd2, "ALARM");
        push_b(0, 2'd2, 8'h1A);
    endtask

    // Decodes one frame at a time, sampling mid-bit, and scores it against the queue.
    task automatic mon(input int w);
        logic [7:0]  d;
        logic        sb;
        logic [1:0]  ch;
        logic [10:0] got, exp;
        int          ep, qs;
        forever begin
            do @(negedge clk); while (get_tx(w) !== 1'b0);
            ep = epoch;
            repeat (5) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (10) @(negedge clk);
                d[i] = get_tx(w);
            end
            repeat (10) @(negedge clk);
            sb  = get_tx(w);
            ch  = get_ach(w);
            got = {ch, sb, d};
            if (ep == epoch) begin
                qs = (w == 0) ? qa.size() : qb.size();
                check((w == 0) ? "rx_a_expected" : "rx_b_expected", 32'(qs != 0), 32'd1);
                if (qs != 0) begin
                    exp = (w == 0) ? qa.pop_front() : qb.pop_front();
                    check((w == 0) ? "rx_a_byte" : "rx_b_byte", 32'(got), 32'(exp));
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        rst = 1'b1; trig_a = '0; trig_b = '0; clr_a = 1'b0; clr_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx",   32'(tx_a),   32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ach",  32'(ach_a),  32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pend", 32'(pend_a), 32'd0);
        check("rst_b_tx", 32'(tx_b),   32'd1);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single ch0 string: latency, byte timing and gap length.
        push_ch0();
        trig_a = 3'b001;
        @(negedge clk);
        check("t1_pend_set", 32'(pend_a), 32'd1);
        trig_a = '0;
        @(negedge clk);
        check("t1_busy",     32'(busy_a), 32'd1);
        check("t1_ach",      32'(ach_a),  32'd0);
        check("t1_pend_clr", 32'(pend_a), 32'd0);
        check("t1_tx_load",  32'(tx_a),   32'd1);
        @(negedge clk);
        check("t1_start_bit", 32'(tx_a), 32'd0);
        wait_for(0, 0, 1000, "t1_done_seen", n);
        check("t1_done_lat", 32'(n), 32'd302);
        wait_for(0, 1, 400, "t1_idle_seen", n);
        check("t1_gap_len", 32'(n), 32'd100);

        // Simultaneous ch1/ch2 requests: ch1 first, ch2 after the gap.
        push_ch1();
        push_ch2();
        trig_a = 3'b110;
        @(negedge clk);
        check("t2_pend_both", 32'(pend_a), 32'd6);
        trig_a = '0;
        @(negedge clk);
        check("t2_ach1",  32'(ach_a),  32'd1);
        check("t2_pend4", 32'(pend_a), 32'd4);
        repeat (500) @(negedge clk);
        check("t2_pend_hold", 32'(pend_a), 32'd4);
        wait_for(0, 0, 1500, "t2_done1_seen", n);
        wait_for(0, 1, 400, "t2_idle1_seen", n);
        check("t2_gap_len", 32'(n), 32'd100);
        @(negedge clk);
        check("t2_busy2", 32'(busy_a), 32'd1);
        check("t2_ach2",  32'(ach_a),  32'd2);
        check("t2_pend0", 32'(pend_a), 32'd0);
        wait_for(0, 0, 3000, "t2_done2_seen", n);
        wait_for(0, 1, 400, "t2_idle2_seen", n);

        // Held trigger sends once; re-raise during the gap re-arms.
        push_ch0();
        trig_a = 3'b001;
        @(negedge clk);
        check("t3_pend_set", 32'(pend_a), 32'd1);
        repeat (498) @(negedge clk);
        check("t3_held_busy", 32'(busy_a), 32'd0);
        check("t3_held_pend", 32'(pend_a), 32'd0);
        trig_a = '0;
        @(negedge clk);
        push_ch0();
        trig_a = 3'b001;
        @(negedge clk);
        trig_a = '0;
        wait_for(0, 0, 1000, "t3_done_seen", n);
        repeat (20) @(negedge clk);
        push_ch0();
        trig_a = 3'b001;
        @(negedge clk);
        check("t3_rearm", 32'(pend_a), 32'd1);
        trig_a = '0;
        wait_for(0, 1, 400, "t3_idle_seen", n);
        check("t3_gap_rem", 32'(n), 32'd79);
        @(negedge clk);
        check("t3_restart_busy", 32'(busy_a), 32'd1);
        check("t3_restart_ach",  32'(ach_a),  32'd0);
        check("t3_restart_pend", 32'(pend_a), 32'd0);
        wait_for(0, 0, 1000, "t3_done2_seen", n);
        wait_for(0, 1, 400, "t3_idle2_seen", n);

        // Reset during bit 4 of byte 1 of the ch1 string.
        push_ch1();
        trig_a = 3'b010;
        @(negedge clk);
        trig_a = '0;
        @(negedge clk);
        repeat (20) @(negedge clk);
        trig_a = 3'b100;
        @(negedge clk);
        trig_a = '0;
        check("t4_pend4", 32'(pend_a), 32'd4);
        repeat (134) @(negedge clk);
        check("t4_busy_pre", 32'(busy_a), 32'd1);
        rst = 1'b1;
        epoch++;
        qa.delete();
        @(negedge clk);
        check("t4_tx",   32'(tx_a),   32'd1);
        check("t4_busy", 32'(busy_a), 32'd0);
        check("t4_pend", 32'(pend_a), 32'd0);
        check("t4_done", 32'(done_a), 32'd0);
        rst = 1'b0;
        nd = 0; nb = 0;
        repeat (1200) begin
            @(negedge clk);
            if (done_a === 1'b1) nd++;
            if (busy_a === 1'b1) nb++;
        end
        check("t4_no_done", 32'(nd), 32'd0);
        check("t4_no_busy", 32'(nb), 32'd0);

        // clr_pending drops ch1; clr coincident with a ch2 rise keeps ch2.
        push_ch0();
        trig_a = 3'b001;
        @(negedge clk);
        trig_a = '0;
        @(negedge clk);
        repeat (50) @(negedge clk);
        trig_a = 3'b010;
        @(negedge clk);
        trig_a = '0;
        check("t5_pend2", 32'(pend_a), 32'd2);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("t5_cleared", 32'(pend_a), 32'd0);
        trig_a = 3'b100;
        clr_a  = 1'b1;
        @(negedge clk);
        trig_a = '0;
        clr_a  = 1'b0;
        check("t5_rise_wins", 32'(pend_a), 32'd4);
        push_ch2();
        wait_for(0, 0, 1000, "t5_done0_seen", n);
        wait_for(0, 1, 400, "t5_idle0_seen", n);
        @(negedge clk);
        check("t5_busy2", 32'(busy_a), 32'd1);
        check("t5_ach2",  32'(ach_a),  32'd2);
        wait_for(0, 0, 3000, "t5_done2_seen", n);
        wait_for(0, 1, 400, "t5_idle2_seen", n);
        repeat (300) @(negedge clk);
        check("t5_no_ch1", 32'(busy_a), 32'd0);
        check("t5_pend_end", 32'(pend_a), 32'd0);

        // MAX_LEN=4 truncates the ch2 string after four bytes.
        push_str(1, 2'd2, "AT+C");
        trig_b = 3'b100;
        @(negedge clk);
        check("t6_pend", 32'(pend_b), 32'd4);
        trig_b = '0;
        @(negedge clk);
        check("t6_ach",  32'(ach_b),  32'd2);
        check("t6_busy", 32'(busy_b), 32'd1);
        wait_for(1, 0, 1000, "t6_done_seen", n);
        check("t6_done_lat", 32'(n), 32'd404);
        @(negedge clk);
        check("t6_done_pulse", 32'(done_b), 32'd0);
        wait_for(1, 1, 400, "t6_idle_seen", n);
        check("t6_gap_len", 32'(n), 32'd99);

        repeat (20) @(negedge clk);
        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
